keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry_pkg.sv | 34 +++
 rtl/keypad_entry_if.sv | 30 +++
 rtl/key_debounce.sv | 87 ++++++++
 rtl/keypad_entry.sv | 110 +++++++++++
 tb/tb_keypad_entry.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg
// Shared constants, debounce FSM state type and key-decoding helpers for the
// keypad entry block (keypad_entry, key_debounce, keypad_entry_if).
package keypad_entry_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned MAX_DIGITS       = 3;
    localparam int unsigned MAX_TENS         = 5;
    localparam int unsigned DEBOUNCE_DEFAULT = 8;
    localparam int unsigned NUM_KEYS         = 10;
    // Wide enough for the largest legal debounce length (255).
    localparam int unsigned CNT_W            = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPressDb   = 2'd1,
        StReleaseDb = 2'd2
    } db_state_e;

    // Exactly one line high is a key; none or several lines count as no key.
    function automatic logic key_is_valid(input logic [NUM_KEYS-1:0] keys);
        return $onehot(keys);
    endfunction

    function automatic logic [BCD_W-1:0] key_to_bcd(input logic [NUM_KEYS-1:0] keys);
        logic [BCD_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) d = BCD_W'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if
// Bundles the keypad entry inputs (raw keys, busy, commit, cancel) and its
// registered outputs (BCD digit buffer, digit count, load/error/accept pulses).
//   master : drives keys/busy/commit/cancel, observes the outputs
//   slave  : the keypad_entry side
interface keypad_entry_if;

    logic [keypad_entry_pkg::NUM_KEYS-1:0] keys;
    logic                                  busy;
    logic                                  commit;
    logic                                  cancel;
    logic [keypad_entry_pkg::BCD_W-1:0]    minutes;
    logic [keypad_entry_pkg::BCD_W-1:0]    tens_sec;
    logic [keypad_entry_pkg::BCD_W-1:0]    units_sec;
    logic [1:0]                            digit_count;
    logic                                  load;
    logic                                  entry_error;
    logic                                  key_accept;

    modport master (
        output keys, busy, commit, cancel,
        input  minutes, tens_sec, units_sec, digit_count, load, entry_error, key_accept
    );

    modport slave (
        input  keys, busy, commit, cancel,
        output minutes, tens_sec, units_sec, digit_count, load, entry_error, key_accept
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce
// Debounces the raw keypad lines: a single key must be stable for
// DEBOUNCE_CYCLES samples to be accepted, and all keys must then read
// released for DEBOUNCE_CYCLES consecutive samples before the next press.
//   clk, clear : clock and synchronous active-high reset
//   keys_i     : raw keypad lines
//   accept_o   : high in the cycle the press is accepted (registered by parent)
//   digit_o    : BCD value of the latched key
module key_debounce
    import keypad_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic                accept_o,
    output logic [BCD_W-1:0]    digit_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES);

    db_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] code_q, code_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        accept_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_is_valid(keys_i)) begin
                    state_d = StPressDb;
                    code_d  = keys_i;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPressDb: begin
                if (keys_i != code_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_inc == CntLast) begin
                    state_d  = StReleaseDb;
                    cnt_d    = '0;
                    accept_o = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StReleaseDb: begin
                // Any line bouncing high restarts the release window.
                if (keys_i != '0) begin
                    cnt_d = '0;
                end else if (cnt_inc == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign digit_o = key_to_bcd(code_q);

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
// Microwave keypad time entry: debounced digits shift into a three-digit BCD
// buffer (minutes, tens of seconds, seconds); a start edge either loads the
// timer or flags an invalid entry; cancel empties the buffer.
//   clk, clear : clock and synchronous active-high reset
//   kp_io      : keypad_entry_if slave (keys/busy/commit/cancel in,
//                digits, digit_count, load, entry_error, key_accept out)
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic          clk,
    input  logic          clear,
    keypad_entry_if.slave kp_io
);

    logic             db_accept;
    logic [BCD_W-1:0] db_digit;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .clear   (clear),
        .keys_i  (kp_io.keys),
        .accept_o(db_accept),
        .digit_o (db_digit)
    );

    logic [BCD_W-1:0] min_q, min_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] units_q, units_d;
    logic [1:0]       count_q, count_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic             accept_q, accept_d;
    logic             commit_q, commit_d;
    logic             commit_edge;
    logic             commit_ok;

    always_comb begin
        commit_edge = kp_io.commit & ~commit_q;
        commit_ok   = (count_q != 2'd0) && (tens_q <= BCD_W'(MAX_TENS));

        min_d    = min_q;
        tens_d   = tens_q;
        units_d  = units_q;
        count_d  = count_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        accept_d = db_accept;
        commit_d = kp_io.commit;

        // Cancel beats commit beats digit entry; a digit arriving alongside
        // either is dropped. The cycle after a load pulse empties the buffer.
        if (kp_io.cancel) begin
            min_d   = '0;
            tens_d  = '0;
            units_d = '0;
            count_d = '0;
        end else if (commit_edge) begin
            if (!kp_io.busy) begin
                if (commit_ok) load_d = 1'b1;
                else           err_d  = 1'b1;
            end
        end else if (load_q) begin
            min_d   = '0;
            tens_d  = '0;
            units_d = '0;
            count_d = '0;
        end else if (db_accept && !kp_io.busy && (count_q < 2'(MAX_DIGITS))) begin
            min_d   = tens_q;
            tens_d  = units_q;
            units_d = db_digit;
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            min_q    <= '0;
            tens_q   <= '0;
            units_q  <= '0;
            count_q  <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            accept_q <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            min_q    <= min_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            count_q  <= count_d;
            load_q   <= load_d;
            err_q    <= err_d;
            accept_q <= accept_d;
            commit_q <= commit_d;
        end
    end

    assign kp_io.minutes     = min_q;
    assign kp_io.tens_sec    = tens_q;
    assign kp_io.units_sec   = units_q;
    assign kp_io.digit_count = count_q;
    assign kp_io.load        = load_q;
    assign kp_io.entry_error = err_q;
    assign kp_io.key_accept  = accept_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
// Directed stimulus against keypad_entry with a behavioural reference model
// (digit buffer kept as a queue) checked every cycle, plus literal checks.
module tb_keypad_entry;
    import keypad_entry_pkg::*;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    keypad_entry_if kp ();

    keypad_entry #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .kp_io(kp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int acc_seen = 0;
    int load_seen = 0;
    int err_seen = 0;

    // Reference model state
    bit         m_started = 1'b0;
    bit         m_pressing = 1'b0;
    bit         m_releasing = 1'b0;
    logic [9:0] m_key = '0;
    int         m_run = 0;
    bit         m_commit_prev = 1'b0;
    bit         m_clear_pending = 1'b0;
    int         m_digits[$];
    bit         exp_load = 1'b0;
    bit         exp_err = 1'b0;
    bit         exp_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // k = 0 is the rightmost (most recently entered) digit.
    function automatic int digit_at(input int k);
        if (m_digits.size() > k) return m_digits[m_digits.size() - 1 - k];
        return 0;
    endfunction

    function automatic int key_index(input logic [9:0] k);
        int r;
        r = 0;
        for (int i = 0; i < 10; i++) if (k[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        bit acc;
        bit cedge;
        bit clr_now;
        if (clear) begin
            m_started = 1'b1;
            m_pressing = 1'b0;
            m_releasing = 1'b0;
            m_key = '0;
            m_run = 0;
            m_commit_prev = 1'b0;
            m_clear_pending = 1'b0;
            m_digits.delete();
            exp_load = 1'b0;
            exp_err = 1'b0;
            exp_acc = 1'b0;
            return;
        end
        acc = 1'b0;
        if (m_pressing) begin
            if (kp.keys != m_key) begin
                m_pressing = 1'b0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    acc = 1'b1;
                    m_pressing = 1'b0;
                    m_releasing = 1'b1;
                    m_run = 0;
                end
            end
        end else if (m_releasing) begin
            if (kp.keys != '0) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    m_releasing = 1'b0;
                    m_run = 0;
                end
            end
        end else if ($onehot(kp.keys)) begin
            m_pressing = 1'b1;
            m_key = kp.keys;
            m_run = 1;
        end

        cedge = kp.commit && !m_commit_prev;
        m_commit_prev = kp.commit;
        clr_now = m_clear_pending;
        m_clear_pending = 1'b0;
        exp_load = 1'b0;
        exp_err = 1'b0;
        exp_acc = acc;
        if (kp.cancel) begin
            m_digits.delete();
        end else if (cedge) begin
            if (!kp.busy) begin
                if (m_digits.size() > 0 && digit_at(1) <= 5) begin
                    exp_load = 1'b1;
                    m_clear_pending = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else if (clr_now) begin
            m_digits.delete();
        end else if (acc && !kp.busy && m_digits.size() < 3) begin
            m_digits.push_back(key_index(m_key));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("key_accept", 32'(kp.key_accept), 32'(exp_acc));
                check("load", 32'(kp.load), 32'(exp_load));
                check("entry_error", 32'(kp.entry_error), 32'(exp_err));
                check("minutes", 32'(kp.minutes), digit_at(2));
                check("tens_sec", 32'(kp.tens_sec), digit_at(1));
                check("units_sec", 32'(kp.units_sec), digit_at(0));
                check("digit_count", 32'(kp.digit_count), m_digits.size());
                if (kp.key_accept === 1'b1) acc_seen++;
                if (kp.load === 1'b1) load_seen++;
                if (kp.entry_error === 1'b1) err_seen++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_digit(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        kp.keys = k;
        tick(DB);
        kp.keys = '0;
        tick(DB);
    endtask

    task automatic do_cancel();
        kp.cancel = 1'b1;
        tick(1);
        kp.cancel = 1'b0;
        tick(1);
    endtask

    int a0, a1, l0, e0;

    initial begin
        kp.keys = '0;
        kp.busy = 1'b0;
        kp.commit = 1'b0;
        kp.cancel = 1'b0;
        clear = 1'b1;
        tick(2);
        clear = 1'b0;
        check("reset_count", 32'(kp.digit_count), 0);
        check("reset_units", 32'(kp.units_sec), 0);
        check("reset_load", 32'(kp.load), 0);
        check("reset_accept", 32'(kp.key_accept), 0);

        // Key 3 held 8 cycles, released 8
        kp.keys = 10'd1 << 3;
        tick(DB - 1);
        check("accept_not_early", 32'(kp.key_accept), 0);
        tick(1);
        check("accept_latency", 32'(kp.key_accept), 1);
        kp.keys = '0;
        tick(DB);
        check("k3_units", 32'(kp.units_sec), 3);
        check("k3_count", 32'(kp.digit_count), 1);
        check("k3_accepts", acc_seen, 1);
        check("k3_fsm_idle", 32'(dut.u_debounce.state_q), 32'(StIdle));
        do_cancel();
        check("cancel_count", 32'(kp.digit_count), 0);

        // Key 7 bouncing, then stable
        a0 = acc_seen;
        repeat (3) begin
            kp.keys = 10'd1 << 7;
            tick(3);
            kp.keys = '0;
            tick(1);
        end
        check("bounce_no_accept", acc_seen - a0, 0);
        kp.keys = 10'd1 << 7;
        tick(DB);
        kp.keys = '0;
        tick(DB);
        check("bounce_one_accept", acc_seen - a0, 1);
        check("bounce_units", 32'(kp.units_sec), 7);
        do_cancel();

        // Two keys at once never count
        a0 = acc_seen;
        kp.keys = 10'b00_0000_0011;
        tick(2 * DB);
        kp.keys = '0;
        tick(2);
        check("multi_key_ignored", acc_seen - a0, 0);

        // Commit with empty buffer
        kp.commit = 1'b1;
        tick(1);
        check("empty_commit_err", 32'(kp.entry_error), 1);
        check("empty_commit_load", 32'(kp.load), 0);
        kp.commit = 1'b0;
        tick(2);

        // 1,3,0 then commit
        enter_digit(1);
        enter_digit(3);
        enter_digit(0);
        kp.commit = 1'b1;
        tick(1);
        check("load_pulse", 32'(kp.load), 1);
        check("load_min", 32'(kp.minutes), 1);
        check("load_tens", 32'(kp.tens_sec), 3);
        check("load_units", 32'(kp.units_sec), 0);
        tick(1);
        check("load_done", 32'(kp.load), 0);
        check("after_load_min", 32'(kp.minutes), 0);
        check("after_load_tens", 32'(kp.tens_sec), 0);
        check("after_load_count", 32'(kp.digit_count), 0);
        kp.commit = 1'b0;
        tick(1);

        // 1,7,0 then commit -> error, buffer kept, held level evaluated once
        enter_digit(1);
        enter_digit(7);
        enter_digit(0);
        l0 = load_seen;
        e0 = err_seen;
        kp.commit = 1'b1;
        tick(1);
        check("bad_tens_err", 32'(kp.entry_error), 1);
        tick(3);
        check("bad_tens_no_load", load_seen - l0, 0);
        check("bad_tens_one_err", err_seen - e0, 1);
        check("bad_tens_min", 32'(kp.minutes), 1);
        check("bad_tens_tens", 32'(kp.tens_sec), 7);
        check("bad_tens_count", 32'(kp.digit_count), 3);
        kp.commit = 1'b0;
        tick(1);
        do_cancel();

        // Four digits; fourth discarded but still acknowledged
        a0 = acc_seen;
        enter_digit(1);
        enter_digit(2);
        enter_digit(3);
        enter_digit(4);
        check("four_accepts", acc_seen - a0, 4);
        check("four_min", 32'(kp.minutes), 1);
        check("four_tens", 32'(kp.tens_sec), 2);
        check("four_units", 32'(kp.units_sec), 3);
        check("four_count", 32'(kp.digit_count), 3);
        l0 = load_seen;
        e0 = err_seen;
        kp.busy = 1'b1;
        kp.commit = 1'b1;
        tick(3);
        kp.busy = 1'b0;
        tick(3);
        kp.commit = 1'b0;
        tick(1);
        check("busy_commit_no_load", load_seen - l0, 0);
        check("busy_commit_no_err", err_seen - e0, 0);
        do_cancel();

        // Digit while busy is discarded but pulsed
        a0 = acc_seen;
        kp.busy = 1'b1;
        enter_digit(5);
        kp.busy = 1'b0;
        check("busy_digit_pulse", acc_seen - a0, 1);
        check("busy_digit_count", 32'(kp.digit_count), 0);

        // Clear in mid-debounce
        a0 = acc_seen;
        kp.keys = 10'd1 << 5;
        tick(4);
        clear = 1'b1;
        kp.keys = '0;
        tick(1);
        clear = 1'b0;
        tick(2 * DB);
        check("clear_no_accept", acc_seen - a0, 0);
        check("clear_count", 32'(kp.digit_count), 0);

        // Cancel and commit together
        enter_digit(2);
        check("pre_cancel_count", 32'(kp.digit_count), 1);
        l0 = load_seen;
        a1 = err_seen;
        kp.cancel = 1'b1;
        kp.commit = 1'b1;
        tick(1);
        check("cancel_commit_load", 32'(kp.load), 0);
        check("cancel_commit_count", 32'(kp.digit_count), 0);
        kp.cancel = 1'b0;
        tick(2);
        kp.commit = 1'b0;
        tick(2);
        check("cancel_commit_no_load", load_seen - l0, 0);
        check("cancel_commit_no_err", err_seen - a1, 0);
        check("cancel_commit_units", 32'(kp.units_sec), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
